spi_transfer_sequencer: RTL
===========================

SPI_TRANSFER_SEQUENCER -- requirements
Module: spi_transfer_sequencer

Interface
REQ-001 SHALL have parameter NUM_CS, default 1: number of chip-select lines.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: maximum bits per transfer.
REQ-003 SHALL have parameter DIV_WIDTH, default 8: width of the clock-divider field.
REQ-004 SHALL have port CLK100MHZ  in  1  system clock; the single clock, all logic on its rising edge.
REQ-005 SHALL have port resetn  in  1  asynchronous active-low reset.
REQ-006 SHALL have port start  in  1  transfer request, sampled only in IDLE.
REQ-007 SHALL have port tx_data  in  DATA_WIDTH  transmit word; bits [length-1:0] are sent MSB first.
REQ-008 SHALL have port length  in  clog2(DATA_WIDTH+1)  bit count of the transfer.
REQ-009 SHALL have port clk_div  in  DIV_WIDTH  half-period of SCK, equal to clk_div+1 cycles.
REQ-010 SHALL have port cs_sel  in  NUM_CS  chip selects to assert during the transfer.
REQ-011 SHALL have port sdi  in  1  serial input from the slave, used only under REQ-032.
REQ-012 SHALL have port busy  out  1  high from the cycle after an accepted start until done.
REQ-013 SHALL have port done  out  1  single-cycle completion pulse.
REQ-014 SHALL have port sck_next, cs_next, sdo, slave_en  out  1 each  drive the registered SPI output stage.
REQ-015 SHALL have port cs_val  out  NUM_CS  latched cs_sel.
REQ-016 SHALL have port rx_data  out  DATA_WIDTH  received word.

Function
REQ-017 SHALL implement the FSM states IDLE, CS_SETUP, SCK_LOW, SCK_HIGH and CS_HOLD.
REQ-018 SHALL hold each non-IDLE state for exactly clk_div+1 cycles, using a down-counter reloaded on every state entry.
REQ-019 On start=1 in IDLE with length!=0, SHALL latch tx_data, length, clk_div and cs_sel on that edge and enter CS_SETUP.
REQ-020 SHALL clamp length>DATA_WIDTH to DATA_WIDTH, and SHALL ignore start when length=0 (no busy, no done).
REQ-021 SHALL ignore start while busy=1, leaving latched values unchanged.
REQ-022 SHALL sequence CS_SETUP->SCK_LOW->SCK_HIGH, then SCK_HIGH->SCK_LOW while bits remain, and SCK_HIGH->CS_HOLD after the last bit, then CS_HOLD->IDLE.
REQ-023 SHALL drive sck_next=1 only in SCK_HIGH, and cs_next=1 in CS_SETUP, SCK_LOW, SCK_HIGH and CS_HOLD.
REQ-024 SHALL drive slave_en=0 while busy and slave_en=1 in IDLE.
REQ-025 SHALL present the current bit on sdo from CS_SETUP entry, advancing to the next bit only on the SCK_HIGH exit edge (mode-0 timing: slave samples on the rising edge).
REQ-026 SHALL drive sdo=0 in IDLE and CS_HOLD.
REQ-027 SHALL make total busy time exactly (2*length+2)*(clk_div+1) cycles.
REQ-028 SHALL pulse done for one cycle on the edge that enters IDLE from CS_HOLD, and SHALL drop busy on the same edge.
REQ-029 SHALL accept a start presented in the cycle done=1, so back-to-back transfers are separated by exactly one IDLE cycle.
REQ-030 SHALL hold cs_val at the latched cs_sel while busy, and at 0 in IDLE.

Reset
REQ-031 While resetn=0, SHALL be in state IDLE with busy=0, done=0, sck_next=0, cs_next=0, sdo=0, slave_en=1, cs_val=0, rx_data=0 and all counters 0; assertion mid-transfer aborts it immediately with no done pulse.

Configuration
REQ-032 With SPI_READBACK_EN defined, SHALL shift sdi into rx_data LSB-first-in on each SCK_LOW->SCK_HIGH edge, clear rx_data on start acceptance, and leave rx_data valid and stable from done until the next start; without SPI_READBACK_EN, rx_data SHALL be constant 0, sdi SHALL be unused and no receive register SHALL exist.

Verification
REQ-033 length=8, clk_div=1, tx_data=0xA5, cs_sel=1 -> sdo bits 1,0,1,0,0,1,0,1 on 8 sck_next pulses 2 cycles wide, busy exactly 36 cycles, one done pulse.
REQ-034 start with length=0 -> busy, done and cs_next stay 0; start with length=40 when DATA_WIDTH=32 -> 32 SCK pulses.
REQ-035 Second start pulsed mid-transfer with tx_data=0xFF -> ignored, and the first transfer completes with its original data.
REQ-036 resetn pulsed low during SCK_HIGH of bit 3 -> all outputs take reset values asynchronously, no done, and a fresh transfer then runs normally.
REQ-037 Start held high through done -> second transfer begins after exactly one IDLE cycle with slave_en=1.
REQ-038 SPI_READBACK_EN defined, sdi looped back to sdo, tx_data=0x3C, length=8 -> rx_data=0x3C at done; macro undefined -> rx_data=0.

Source files
------------

// File: rtl/spi_transfer_sequencer.sv
// spi_transfer_sequencer
// Sequences one SPI mode-0 transfer of up to DATA_WIDTH bits, MSB first.
// Each state lasts clk_div+1 cycles:
//   CS_SETUP, then SCK_LOW/SCK_HIGH once per bit, then CS_HOLD.
// The outputs feed a registered SPI pin stage.
// Optional feature macro: SPI_READBACK_EN
//   When defined, sdi is shifted into rx_data on every SCK rising phase.
//   When undefined, rx_data is tied to zero and sdi is ignored.
module spi_transfer_sequencer #(
    parameter int NUM_CS     = 1,
    parameter int DATA_WIDTH = 32,
    parameter int DIV_WIDTH  = 8,
    localparam int LEN_W     = $clog2(DATA_WIDTH + 1)
) (
    input  logic                  CLK100MHZ,
    input  logic                  resetn,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic [LEN_W-1:0]      length,
    input  logic [DIV_WIDTH-1:0]  clk_div,
    input  logic [NUM_CS-1:0]     cs_sel,
    input  logic                  sdi,
    output logic                  busy,
    output logic                  done,
    output logic                  sck_next,
    output logic                  cs_next,
    output logic                  sdo,
    output logic                  slave_en,
    output logic [NUM_CS-1:0]     cs_val,
    output logic [DATA_WIDTH-1:0] rx_data
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CS_SETUP = 3'd1,
        ST_SCK_LOW  = 3'd2,
        ST_SCK_HIGH = 3'd3,
        ST_CS_HOLD  = 3'd4
    } state_t;

    // Select one bit of a word by a run-time index.
    // A shift is used so the index width need not match the word.
    function automatic logic get_bit(input logic [DATA_WIDTH-1:0] vec,
                                     input logic [LEN_W-1:0]      idx);
        logic [DATA_WIDTH-1:0] sh;
        sh = vec >> idx;
        return sh[0];
    endfunction

    state_t                r_state;
    logic [DIV_WIDTH-1:0]  r_cnt;
    logic [DIV_WIDTH-1:0]  r_div;
    logic [DATA_WIDTH-1:0] r_tx;
    logic [LEN_W-1:0]      r_idx;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_sck;
    logic                  r_cs;
    logic                  r_sdo;
    logic                  r_slave_en;
    logic [NUM_CS-1:0]     r_cs_val;

    logic [LEN_W-1:0]      w_len_clamp;
    logic [LEN_W-1:0]      w_first_idx;
    logic                  w_start_ok;
    logic                  w_cnt_zero;

    // Clamp the requested length and qualify a start request.
    // Also detect the last cycle of the current state.
    always_comb begin
        if (length > LEN_W'(DATA_WIDTH)) begin
            w_len_clamp = LEN_W'(DATA_WIDTH);
        end else begin
            w_len_clamp = length;
        end
        w_first_idx = w_len_clamp - LEN_W'(1);
        w_start_ok  = start && (length != LEN_W'(0));
        w_cnt_zero  = (r_cnt == DIV_WIDTH'(0));
    end

    // Transfer state machine.
    // Every output is registered here, and the dwell counter is
    // reloaded on each state entry.
    always_ff @(posedge CLK100MHZ or negedge resetn) begin
        if (!resetn) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_div      <= '0;
            r_tx       <= '0;
            r_idx      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_sck      <= 1'b0;
            r_cs       <= 1'b0;
            r_sdo      <= 1'b0;
            r_slave_en <= 1'b1;
            r_cs_val   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start_ok) begin
                        r_state    <= ST_CS_SETUP;
                        r_cnt      <= clk_div;
                        r_div      <= clk_div;
                        r_tx       <= tx_data;
                        r_idx      <= w_first_idx;
                        r_cs_val   <= cs_sel;
                        r_busy     <= 1'b1;
                        r_cs       <= 1'b1;
                        r_slave_en <= 1'b0;
                        r_sdo      <= get_bit(tx_data, w_first_idx);
                    end else begin
                        r_cnt      <= '0;
                        r_cs_val   <= '0;
                        r_sdo      <= 1'b0;
                        r_sck      <= 1'b0;
                        r_cs       <= 1'b0;
                        r_busy     <= 1'b0;
                        r_slave_en <= 1'b1;
                    end
                end
                ST_CS_SETUP: begin
                    if (w_cnt_zero) begin
                        r_state <= ST_SCK_LOW;
                        r_cnt   <= r_div;
                    end else begin
                        r_cnt <= r_cnt - DIV_WIDTH'(1);
                    end
                end
                ST_SCK_LOW: begin
                    if (w_cnt_zero) begin
                        r_state <= ST_SCK_HIGH;
                        r_cnt   <= r_div;
                        r_sck   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - DIV_WIDTH'(1);
                    end
                end
                ST_SCK_HIGH: begin
                    if (w_cnt_zero) begin
                        r_cnt <= r_div;
                        r_sck <= 1'b0;
                        if (r_idx == LEN_W'(0)) begin
                            // Last bit has been clocked out.
                            r_state <= ST_CS_HOLD;
                            r_sdo   <= 1'b0;
                        end else begin
                            r_state <= ST_SCK_LOW;
                            r_idx   <= r_idx - LEN_W'(1);
                            r_sdo   <= get_bit(r_tx, r_idx - LEN_W'(1));
                        end
                    end else begin
                        r_cnt <= r_cnt - DIV_WIDTH'(1);
                    end
                end
                ST_CS_HOLD: begin
                    if (w_cnt_zero) begin
                        r_state    <= ST_IDLE;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                        r_cs       <= 1'b0;
                        r_slave_en <= 1'b1;
                        r_cs_val   <= '0;
                    end else begin
                        r_cnt <= r_cnt - DIV_WIDTH'(1);
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_cnt      <= '0;
                    r_busy     <= 1'b0;
                    r_sck      <= 1'b0;
                    r_cs       <= 1'b0;
                    r_sdo      <= 1'b0;
                    r_slave_en <= 1'b1;
                    r_cs_val   <= '0;
                end
            endcase
        end
    end

`ifdef SPI_READBACK_EN
    logic [DATA_WIDTH-1:0] r_rx;
    logic                  w_rx_clear;
    logic                  w_rx_shift;

    // Receive strobes.
    // Clear on start acceptance; shift on the SCK_LOW to SCK_HIGH edge.
    always_comb begin
        w_rx_clear = (r_state == ST_IDLE) && w_start_ok;
        w_rx_shift = (r_state == ST_SCK_LOW) && w_cnt_zero;
    end

    // Receive shift register.
    // The first received bit ends up in the MSB position of the transfer.
    always_ff @(posedge CLK100MHZ or negedge resetn) begin
        if (!resetn) begin
            r_rx <= '0;
        end else if (w_rx_clear) begin
            r_rx <= '0;
        end else if (w_rx_shift) begin
            r_rx <= (r_rx << 1) | DATA_WIDTH'(sdi);
        end else begin
            r_rx <= r_rx;
        end
    end

    assign rx_data = r_rx;
`else
    logic w_unused_sdi;
    assign w_unused_sdi = sdi;
    assign rx_data      = '0;
`endif

    assign busy     = r_busy;
    assign done     = r_done;
    assign sck_next = r_sck;
    assign cs_next  = r_cs;
    assign sdo      = r_sdo;
    assign slave_en = r_slave_en;
    assign cs_val   = r_cs_val;

endmodule
